// File: rtl/imdct_engine_sched.sv
// Round-robin scheduler and external-port master for the shared IMDCT/FFT engine.
// One job per grant: load the frame, start the engine, then drain the result through a 2-deep FIFO.
module imdct_engine_sched #(
  parameter int DW      = 32,
  parameter int AW      = 10,
  parameter int TIMEOUT = 8191
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    cfg_tabidx,
  input  logic [1:0]    cfg_mode,
  input  logic [1:0]    cfg_func,
  input  logic [4:0]    es,
  output logic          gnt_id,
  output logic          busy,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          job_end,
  output logic          job_err,
  output logic [DW-1:0] eng_din,
  output logic          eng_we,
  output logic          eng_ram_en,
  output logic [AW-1:0] eng_addr,
  output logic          eng_start,
  output logic          eng_tabidx,
  output logic          eng_mode,
  output logic          eng_func,
  output logic          eng_auto,
  output logic          eng_bit_rev,
  output logic [4:0]    eng_es,
  input  logic [DW-1:0] eng_dout,
  input  logic          eng_done
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN, S_END} state_t;

  state_t        state;
  logic          ptr;
  logic [AW:0]   cnt;
  logic [TW-1:0] tmo;
  logic [AW:0]   last_idx;
  logic          gnt_next;
  logic          load_acc, issue, pop;
  logic [1:0]    occ;

  logic [DW:0]   fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_cnt;
  logic          inflight, inflight_last;

  assign last_idx = eng_tabidx ? (AW+1)'(1023) : (AW+1)'(127);
  assign gnt_next = req[ptr] ? ptr : ~ptr;

  assign in_ready  = (state == S_LOAD);
  assign load_acc  = in_ready & in_valid;
  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  // Occupancy after this cycle's pop plus the word in flight; a new read is safe below 2.
  assign occ       = fifo_cnt - {1'b0, pop} + {1'b0, inflight};
  assign issue     = (state == S_DRAIN) && (cnt <= last_idx) && !occ[1];

  assign eng_we      = load_acc;
  assign eng_ram_en  = load_acc | issue;
  assign eng_addr    = (load_acc | issue) ? cnt[AW-1:0] : '0;
  assign eng_din     = load_acc ? in_data : '0;
  assign eng_auto    = 1'b0;
  assign eng_bit_rev = 1'b0;

  assign out_data = out_valid ? fifo_mem[rd_ptr][DW-1:0] : '0;
  assign out_last = out_valid & fifo_mem[rd_ptr][DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= 1'b0;
      cnt        <= '0;
      tmo        <= '0;
      busy       <= 1'b0;
      gnt_id     <= 1'b0;
      eng_start  <= 1'b0;
      job_end    <= 1'b0;
      job_err    <= 1'b0;
      eng_tabidx <= 1'b0;
      eng_mode   <= 1'b0;
      eng_func   <= 1'b0;
      eng_es     <= '0;
    end else begin
      eng_es <= es;
      case (state)
        S_IDLE: if (|req) begin
          gnt_id     <= gnt_next;
          ptr        <= ~gnt_next;
          eng_tabidx <= cfg_tabidx[gnt_next];
          eng_mode   <= cfg_mode[gnt_next];
          eng_func   <= cfg_func[gnt_next];
          cnt        <= '0;
          busy       <= 1'b1;
          state      <= S_LOAD;
        end
        S_LOAD: if (in_valid) begin
          cnt <= cnt + 1'b1;
          if (cnt == last_idx) begin
            eng_start <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          eng_start <= 1'b0;
          tmo       <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // done takes precedence over an expiry in the same cycle
          if (eng_done) begin
            cnt   <= '0;
            state <= S_DRAIN;
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            job_end <= 1'b1;
            job_err <= 1'b1;
            state   <= S_END;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_DRAIN: begin
          if (issue) cnt <= cnt + 1'b1;
          if (pop && out_last) begin
            job_end <= 1'b1;
            job_err <= 1'b0;
            state   <= S_END;
          end
        end
        S_END: begin
          job_end <= 1'b0;
          job_err <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_cnt      <= 2'd0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (cnt == last_idx);
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (inflight) fifo_mem[wr_ptr] <= {inflight_last, eng_dout};
  end

endmodule
